// File: rtl/multdiv_pipeline_controller.sv
// Sequences the multi-cycle multiply/divide unit: captures operands from DX, pulses the unit start,
// stalls the front of the pipeline while it runs and hands the result and exception status to XM.
module multdiv_pipeline_controller #(
    parameter logic [4:0]  MULT_ALUOP     = 5'b00110,
    parameter logic [4:0]  DIV_ALUOP      = 5'b00111,
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned CNT_W          = 6,
    parameter int unsigned MULT_RSTATUS   = 4,
    parameter int unsigned DIV_RSTATUS    = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      DX_Latch_Instr,
    input  logic             DX_valid,
    input  logic             flush,
    input  logic [31:0]      md_operand_A,
    input  logic [31:0]      md_operand_B,
    input  logic             md_resultRDY,
    input  logic             md_exception,
    input  logic [31:0]      md_result,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic [31:0]      md_data_A,
    output logic [31:0]      md_data_B,
    output logic             pipeline_stall,
    output logic             md_done,
    output logic [31:0]      md_result_out,
    output logic             md_error_out,
    output logic [31:0]      md_rstatus,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cycle_count
);

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutMax  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

    state_e           state_q, state_d;
    logic             op_div_q, op_div_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             ctrl_mult_q, ctrl_mult_d;
    logic             ctrl_div_q, ctrl_div_d;
    logic             done_q, done_d;
    logic [31:0]      result_q, result_d;
    logic             error_q, error_d;
    logic [31:0]      rstatus_q, rstatus_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0] opcode;
    logic [4:0] aluop;
    logic       is_md;
    logic       unused_instr;

    assign opcode       = DX_Latch_Instr[31:27];
    assign aluop        = DX_Latch_Instr[6:2];
    assign is_md        = DX_valid && (opcode == 5'd0) &&
                          ((aluop == MULT_ALUOP) || (aluop == DIV_ALUOP));
    assign unused_instr = ^{DX_Latch_Instr[21:7], DX_Latch_Instr[1:0]};

    always_comb begin
        state_d     = state_q;
        op_div_d    = op_div_q;
        rd_d        = rd_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cnt_d       = cnt_q;
        cnt_inc     = (cnt_q == TimeoutMax) ? cnt_q : cnt_q + 1'b1;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        done_d      = 1'b0;
        result_d    = 32'd0;
        error_d     = 1'b0;
        rstatus_d   = 32'd0;
        count_d     = count_q;

        unique case (state_q)
            StIdle: begin
                if (is_md && !flush) begin
                    state_d     = StStart;
                    op_div_d    = (aluop == DIV_ALUOP);
                    rd_d        = DX_Latch_Instr[26:22];
                    opa_d       = md_operand_A;
                    opb_d       = md_operand_B;
                    ctrl_mult_d = (aluop != DIV_ALUOP);
                    ctrl_div_d  = (aluop == DIV_ALUOP);
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = flush ? StIdle : StWait;
            end
            StWait: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    // A result arriving on the last allowed cycle still wins over the timeout.
                    if (md_resultRDY || (cnt_q == TimeoutLast)) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        count_d   = cnt_inc;
                        error_d   = md_resultRDY ? md_exception : 1'b1;
                        result_d  = (error_d || (rd_q == 5'd0) || !md_resultRDY) ? 32'd0
                                                                                  : md_result;
                        rstatus_d = !error_d ? 32'd0
                                  : (op_div_q ? 32'(DIV_RSTATUS) : 32'(MULT_RSTATUS));
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StStart) || (state_d == StWait);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            op_div_q    <= 1'b0;
            rd_q        <= 5'd0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            cnt_q       <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 32'd0;
            error_q     <= 1'b0;
            rstatus_q   <= 32'd0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_div_q    <= op_div_d;
            rd_q        <= rd_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cnt_q       <= cnt_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            done_q      <= done_d;
            result_q    <= result_d;
            error_q     <= error_d;
            rstatus_q   <= rstatus_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    // Stall is combinational so a new mul/div holds DX in its arrival cycle; it drops on a flush.
    always_comb begin
        pipeline_stall = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                StIdle:          pipeline_stall = is_md && !flush;
                StStart, StWait: pipeline_stall = !flush;
                default:         pipeline_stall = 1'b0;
            endcase
        end
    end

    assign ctrl_MULT      = ctrl_mult_q;
    assign ctrl_DIV       = ctrl_div_q;
    assign md_data_A      = opa_q;
    assign md_data_B      = opb_q;
    assign md_done        = done_q;
    assign md_result_out  = result_q;
    assign md_error_out   = error_q;
    assign md_rstatus     = rstatus_q;
    assign md_busy        = busy_q;
    assign md_cycle_count = count_q;

endmodule

// File: tb/tb_multdiv_pipeline_controller.sv
// Scoreboard bench: the driver plays DX and the multdiv unit, queueing expected start pulses and
// completions; an independent monitor compares them whenever the DUT presents them.
module tb_multdiv_pipeline_controller;

    localparam int TO = 20;
    localparam logic [4:0] MUL_OP = 5'b00110;
    localparam logic [4:0] DIV_OP = 5'b00111;

    logic        clock;
    logic        reset_n;
    logic [31:0] DX_Latch_Instr;
    logic        DX_valid;
    logic        flush;
    logic [31:0] md_operand_A;
    logic [31:0] md_operand_B;
    logic        md_resultRDY;
    logic        md_exception;
    logic [31:0] md_result;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_data_A;
    logic [31:0] md_data_B;
    logic        pipeline_stall;
    logic        md_done;
    logic [31:0] md_result_out;
    logic        md_error_out;
    logic [31:0] md_rstatus;
    logic        md_busy;
    logic [5:0]  md_cycle_count;

    multdiv_pipeline_controller #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(6)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .DX_Latch_Instr(DX_Latch_Instr),
        .DX_valid(DX_valid),
        .flush(flush),
        .md_operand_A(md_operand_A),
        .md_operand_B(md_operand_B),
        .md_resultRDY(md_resultRDY),
        .md_exception(md_exception),
        .md_result(md_result),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .md_data_A(md_data_A),
        .md_data_B(md_data_B),
        .pipeline_stall(pipeline_stall),
        .md_done(md_done),
        .md_result_out(md_result_out),
        .md_error_out(md_error_out),
        .md_rstatus(md_rstatus),
        .md_busy(md_busy),
        .md_cycle_count(md_cycle_count)
    );

    typedef struct {
        int          cyc;
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
    } start_t;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic        err;
        logic [31:0] rst;
        logic [31:0] cnt;
    } done_t;

    start_t start_q[$];
    done_t  done_q[$];
    start_t s_exp;
    done_t  d_exp;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd,
                                       input logic [4:0] aluop);
        return {opc, rd, 15'($urandom), aluop, 2'b00};
    endfunction

    // Monitor: pops expectations only when the DUT presents a start pulse or a completion.
    always @(negedge clock) begin
        if (reset_n) begin
            if (ctrl_MULT || ctrl_DIV) begin
                if (start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got mult=%0b div=%0b expected none (cycle %0d)",
                             ctrl_MULT, ctrl_DIV, cyc);
                end else begin
                    s_exp = start_q.pop_front();
                    chk("start_cycle", cyc, s_exp.cyc);
                    chk("ctrl_MULT", ctrl_MULT, !s_exp.is_div);
                    chk("ctrl_DIV", ctrl_DIV, s_exp.is_div);
                    chk("md_data_A", md_data_A, s_exp.a);
                    chk("md_data_B", md_data_B, s_exp.b);
                end
            end
            if (md_done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got md_done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    d_exp = done_q.pop_front();
                    chk("done_cycle", cyc, d_exp.cyc);
                    chk("md_result_out", md_result_out, d_exp.res);
                    chk("md_error_out", md_error_out, d_exp.err);
                    chk("md_rstatus", md_rstatus, d_exp.rst);
                    chk("md_cycle_count", 32'(md_cycle_count), d_exp.cnt);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        chk({tag, "_data_A"}, md_data_A, 32'd0);
        chk({tag, "_data_B"}, md_data_B, 32'd0);
        chk({tag, "_stall"}, pipeline_stall, 0);
        chk({tag, "_done"}, md_done, 0);
        chk({tag, "_result"}, md_result_out, 32'd0);
        chk({tag, "_error"}, md_error_out, 0);
        chk({tag, "_rstatus"}, md_rstatus, 32'd0);
        chk({tag, "_busy"}, md_busy, 0);
        chk({tag, "_count"}, 32'(md_cycle_count), 32'd0);
    endtask

    // delay = WAIT cycle on which RDY is raised (beyond TO means never); abort_k = WAIT cycle of
    // a flush (or reset when abort_rst), 0 for none. Entered and left just after a rising edge.
    task automatic run_op(input bit is_div, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input int delay, input bit exc,
                          input int abort_k, input bit abort_rst);
        bit          timeout;
        bit          err;
        int          wait_n;
        int          t;
        bit          aborted;
        logic [31:0] r;
        start_t      s;
        done_t       d;

        timeout = (delay > TO);
        wait_n  = timeout ? TO : delay;
        err     = timeout || exc;
        r       = is_div ? ((b == 0) ? 32'd0 : a / b) : a * b;
        aborted = 0;

        DX_Latch_Instr = mk(5'd0, rd, is_div ? DIV_OP : MUL_OP);
        DX_valid       = 1'b1;
        flush          = 1'b0;
        md_operand_A   = a;
        md_operand_B   = b;
        t              = cyc;

        s.cyc = t + 1; s.is_div = is_div; s.a = a; s.b = b;
        start_q.push_back(s);
        if (abort_k == 0) begin
            d.cyc = t + wait_n + 2;
            d.err = err;
            d.res = (err || rd == 5'd0) ? 32'd0 : r;
            d.rst = err ? (is_div ? 32'd5 : 32'd4) : 32'd0;
            d.cnt = 32'(wait_n);
            done_q.push_back(d);
        end

        @(negedge clock);
        chk("stall_issue", pipeline_stall, 1);
        step();
        md_operand_A = $urandom;
        md_operand_B = $urandom;
        @(negedge clock);
        chk("stall_start", pipeline_stall, 1);
        chk("busy_start", md_busy, 1);

        for (int k = 1; k <= wait_n; k++) begin
            step();
            md_resultRDY = !timeout && (k == delay);
            md_exception = (k == delay) ? exc : 1'($urandom);
            md_result    = (k == delay) ? r : $urandom;
            if (k == abort_k) begin
                aborted = 1;
                if (abort_rst) begin
                    #1 reset_n = 1'b0;
                    #1 check_all_zero("reset_mid");
                end else begin
                    flush = 1'b1;
                    @(negedge clock);
                    chk("stall_abort", pipeline_stall, 0);
                end
                break;
            end
            @(negedge clock);
            chk("stall_wait", pipeline_stall, 1);
        end

        if (!aborted) begin
            step();
            md_resultRDY = 1'b0;
            @(negedge clock);
            chk("stall_done", pipeline_stall, 0);
            chk("busy_done", md_busy, 0);
            step();
            DX_valid = 1'b0;
        end else if (!abort_rst) begin
            step();
            flush    = 1'b0;
            DX_valid = 1'b0;
            step();
            md_resultRDY = 1'b1;
            @(negedge clock);
            chk("busy_after_flush", md_busy, 0);
            step();
            md_resultRDY = 1'b0;
        end else begin
            step();
            step();
            DX_valid = 1'b0;
            reset_n  = 1'b1;
            step();
            md_resultRDY = 1'b1;
            @(negedge clock);
            chk("busy_after_reset", md_busy, 0);
            step();
            md_resultRDY = 1'b0;
        end
    endtask

    // Non-starting DX contents: foreign opcode, non-md aluop, invalid, or flushed.
    task automatic noise(input int kind);
        DX_valid = 1'b1;
        flush    = 1'b0;
        unique case (kind)
            0:       DX_Latch_Instr = mk(5'($urandom_range(1, 31)), 5'd3, MUL_OP);
            1:       DX_Latch_Instr = mk(5'd0, 5'd3, 5'b00000);
            2: begin DX_Latch_Instr = mk(5'd0, 5'd3, DIV_OP); DX_valid = 1'b0; end
            default: begin DX_Latch_Instr = mk(5'd0, 5'd3, MUL_OP); flush = 1'b1; end
        endcase
        md_resultRDY = 1'($urandom);
        @(negedge clock);
        chk("stall_noise", pipeline_stall, 0);
        step();
        DX_valid     = 1'b0;
        flush        = 1'b0;
        md_resultRDY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          dv;
        bit          ex;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;

        reset_n        = 1'b0;
        DX_Latch_Instr = 32'd0;
        DX_valid       = 1'b0;
        flush          = 1'b0;
        md_operand_A   = 32'd0;
        md_operand_B   = 32'd0;
        md_resultRDY   = 1'b0;
        md_exception   = 1'b0;
        md_result      = 32'd0;

        step();
        step();
        @(negedge clock);
        check_all_zero("reset");
        step();
        reset_n = 1'b1;
        step();

        run_op(0, 5'd5, 32'd7, 32'd6, 16, 0, 0, 0);
        run_op(1, 5'd3, 32'd10, 32'd0, 5, 1, 0, 0);
        run_op(0, 5'd7, 32'd9, 32'd9, 10, 0, 3, 0);
        run_op(0, 5'd9, 32'd2, 32'd3, TO + 5, 0, 0, 0);
        run_op(1, 5'd4, 32'd100, 32'd7, TO, 0, 0, 0);
        run_op(0, 5'd0, 32'd3, 32'd4, 2, 0, 0, 0);
        run_op(0, 5'd1, 32'd11, 32'd13, 1, 0, 0, 0);
        run_op(1, 5'd2, 32'd99, 32'd9, 3, 0, 0, 0);
        run_op(0, 5'd6, 32'd5, 32'd5, 10, 0, 4, 1);
        run_op(1, 5'd8, 32'd77, 32'd0, TO + 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) noise(i);

        repeat (30) begin
            if ($urandom_range(0, 4) == 0) begin
                noise($urandom_range(0, 3));
            end else begin
                dv = 1'($urandom);
                rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                a  = $urandom;
                b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                ex = (dv && b == 0) || ($urandom_range(0, 4) == 0);
                run_op(dv, rd, a, b, $urandom_range(1, TO + 3), ex, 0, 0);
            end
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        step();
        chk("start_queue_empty", start_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_pipeline_controller.md
Name: multdiv_pipeline_controller

Overview:
Sequences the multi-cycle multiply/divide unit for the 5-stage pipeline. It detects R-type mul/div in the DX latch, captures the bypassed ALU operands, and pulses ctrl_MULT/ctrl_DIV. While the unit runs it holds the front of the pipeline. On completion it releases the instruction to XM with its result and exception status, which feed the XM error-flag/rstatus path used by the hazard logic.

Parameters:
MULT_ALUOP, 5'b00110, ALU op field value for mul
DIV_ALUOP, 5'b00111, ALU op field value for div
TIMEOUT_CYCLES, 40, max WAIT cycles before forced error completion (>=2)
CNT_W, 6, cycle counter width; must hold TIMEOUT_CYCLES
MULT_RSTATUS, 4, rstatus code for mul exception/timeout
DIV_RSTATUS, 5, rstatus code for div exception/timeout

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
DX_Latch_Instr  in  32  instruction in DX latch
DX_valid  in  1  DX latch holds a live (non-nop, non-squashed) instruction
flush  in  1  taken branch/jump squashing DX this cycle
md_operand_A  in  32  bypassed ALU A input (after bypass/exception muxes)
md_operand_B  in  32  bypassed ALU B input
md_resultRDY  in  1  multdiv unit result valid
md_exception  in  1  multdiv unit exception, valid with md_resultRDY
md_result  in  32  multdiv unit result
ctrl_MULT  out  1  one-cycle start pulse, multiply
ctrl_DIV  out  1  one-cycle start pulse, divide
md_data_A  out  32  latched operand A to unit
md_data_B  out  32  latched operand B to unit
pipeline_stall  out  1  hold PC, FD and DX; insert nop into XM
md_done  out  1  one-cycle pulse: DX mul/div advances to XM this cycle
md_result_out  out  32  result to XM O latch, valid with md_done
md_error_out  out  1  to XM error-flag latch, valid with md_done
md_rstatus  out  32  rstatus value when md_error_out=1, else 0
md_busy  out  1  state is START or WAIT
md_cycle_count  out  CNT_W  WAIT cycles consumed by last completed op

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; operand, result and rd registers 0. Reset mid-operation aborts with no md_done.
- is_md = DX_valid & opcode[31:27]==0 & (aluop[6:2]==MULT_ALUOP | DIV_ALUOP).
- States: IDLE, START, WAIT, DONE.
- IDLE: if is_md & !flush, latch md_operand_A/B, rd[26:22] and op type, then go to START. pipeline_stall=is_md&!flush (combinational, same cycle).
- START: ctrl_MULT or ctrl_DIV=1 for exactly this cycle. Counter cleared. Go to WAIT. Stall=1.
- WAIT: stall=1. Counter increments each cycle (saturates at TIMEOUT_CYCLES).
  - md_resultRDY sampled high: capture md_result, md_exception, count; go to DONE.
  - Otherwise, once counter==TIMEOUT_CYCLES-1: go to DONE with error=1, result=0.
  - RDY takes priority over timeout in the same cycle.
- DONE: md_done=1, stall=0, outputs valid for this cycle only; next state IDLE. DX advances this cycle, so the next is_md is evaluated fresh in IDLE.
- Error: md_rstatus = MULT_RSTATUS or DIV_RSTATUS by op type. md_result_out=0 when error.
- rd==0 without error: md_result_out forced 0; md_done still pulses.
- flush in START or WAIT: abort to IDLE next cycle. No md_done. Late md_resultRDY is ignored. Stall drops in the abort cycle.
- md_resultRDY outside WAIT is ignored.
- md_data_A/B are held stable from START until the next capture.
- Latency: DX arrival at cycle t → ctrl pulse at t+1 → RDY sampled at cycle w → md_done at w+1.

Test Plan:
- mul 7×6, rd=5, RDY 16 cycles after ctrl_MULT → ctrl_MULT one pulse at t+1; stall high t..w; md_done at w+1 with result 42, error 0, md_cycle_count=16.
- div 10÷0 with md_exception=1 on RDY → md_done, md_error_out=1, md_rstatus=5, md_result_out=0.
- mul in DX, flush asserted in 3rd WAIT cycle, RDY arrives 2 cycles later → no md_done, stall low from abort cycle, IDLE.
- TIMEOUT_CYCLES=8, RDY never asserted → md_done at WAIT cycle 8 +1, error=1, rstatus=4.
- Back-to-back mul then div in consecutive DX → two separate START pulses (ctrl_MULT then ctrl_DIV), one md_done each, IDLE gap of ≥1 cycle stalled.
- reset_n low mid-WAIT → all outputs 0 immediately; after release, RDY pulse produces no md_done.
